// File: rtl/proc_flex_if.sv
// Instruction/status bundle between proc_flex and its instruction source.
// The debug read port rides along so a wrapper can observe any register.
interface proc_flex_if #(
  parameter int DW = 16
);
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;
  logic [2:0]    Flags;
  logic [2:0]    DbgSel;
  logic [DW-1:0] DbgData;

  modport master (
    output DIN, Run, DbgSel,
    input  Done, Flags, DbgData
  );

  modport slave (
    input  DIN, Run, DbgSel,
    output Done, Flags, DbgData
  );
endinterface

// File: rtl/proc_flex.sv
// Multicycle bus-based processor core: eight registers, A/G accumulators,
// T0..T3 step FSM under Run/Done control, N/Z/C flags and a debug read port.
module proc_flex #(
  parameter int DW         = 16,
  parameter bit SIGNED_IMM = 1'b0
) (
  input  logic        Clock,
  input  logic        Resetn,
  proc_flex_if.slave  io
);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_RX, SEL_RY, SEL_IMM, SEL_MVT, SEL_G} sel_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  step_t         step_q, step_d;
  sel_t          bus_sel;
  logic [15:0]   ir;
  logic [DW-1:0] regs [8];
  logic [DW-1:0] a_q, g_q;
  logic [2:0]    flags_q;
  logic [DW-1:0] bus_w;
  logic [DW:0]   alu_w;
  logic          r_we, a_we, g_we, f_we, done;

  logic [2:0] op, rx, ry;
  logic       imm_m;

  assign op    = ir[15:13];
  assign imm_m = ir[12];
  assign rx    = ir[11:9];
  assign ry    = ir[2:0];

  function automatic logic [DW-1:0] ext_imm(input logic [8:0] d);
    logic signed [8:0] d_s;
    d_s = $signed(d);
    if (SIGNED_IMM) return DW'(d_s);
    return DW'(d);
  endfunction

  // Bit DW of the result carries the C flag: carry-out for add,
  // not-borrow for sub/cmp, zero for the logical ops.
  function automatic logic [DW:0] alu(input logic [2:0] opc,
                                      input logic [DW-1:0] a,
                                      input logic [DW-1:0] b);
    logic [DW:0] r;
    case (opc)
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: begin
        r = {1'b0, a} - {1'b0, b};
        r = {~r[DW], r[DW-1:0]};
      end
      OP_AND:         r = {1'b0, a & b};
      OP_OR:          r = {1'b0, a | b};
      OP_XOR:         r = {1'b0, a ^ b};
      default:        r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    step_d  = step_q;
    bus_sel = SEL_NONE;
    r_we    = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    f_we    = 1'b0;
    done    = 1'b0;
    case (step_q)
      T0: if (io.Run) step_d = T1;
      T1: begin
        if (op == OP_MV || op == OP_MVT) begin
          if (op == OP_MVT) bus_sel = SEL_MVT;
          else              bus_sel = imm_m ? SEL_IMM : SEL_RY;
          r_we   = 1'b1;
          done   = 1'b1;
          step_d = T0;
        end else begin
          bus_sel = SEL_RX;
          a_we    = 1'b1;
          step_d  = T2;
        end
      end
      T2: begin
        bus_sel = imm_m ? SEL_IMM : SEL_RY;
        g_we    = 1'b1;
        f_we    = 1'b1;
        if (op == OP_CMP) begin
          done   = 1'b1;
          step_d = T0;
        end else begin
          step_d = T3;
        end
      end
      T3: begin
        bus_sel = SEL_G;
        r_we    = 1'b1;
        done    = 1'b1;
        step_d  = T0;
      end
      default: step_d = T0;
    endcase
  end

  always_comb begin
    bus_w = '0;
    case (bus_sel)
      SEL_RX:  bus_w = regs[rx];
      SEL_RY:  bus_w = regs[ry];
      SEL_IMM: bus_w = ext_imm(ir[8:0]);
      SEL_MVT: bus_w = DW'({ir[7:0], 8'h00});
      SEL_G:   bus_w = g_q;
      default: bus_w = '0;
    endcase
  end

  assign alu_w = alu(op, a_q, bus_w);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      step_q  <= T0;
      ir      <= '0;
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      regs    <= '{default: '0};
    end else begin
      step_q <= step_d;
      if (step_q == T0) ir <= io.DIN;
      if (a_we) a_q <= bus_w;
      if (g_we) g_q <= alu_w[DW-1:0];
      if (f_we) flags_q <= {alu_w[DW-1], alu_w[DW-1:0] == '0, alu_w[DW]};
      if (r_we) regs[rx] <= bus_w;
    end
  end

  assign io.Done    = done;
  assign io.Flags   = flags_q;
  assign io.DbgData = regs[io.DbgSel];

endmodule

// File: tb/tb_proc_flex.sv
// Scoreboard bench for proc_flex: three configurations (16-bit zero-ext,
// 16-bit sign-ext, 32-bit), directed instruction vectors, reset-abort case.
module tb_proc_flex;

  logic Clock;
  logic Resetn;
  int   cyc = 0;

  proc_flex_if #(.DW(16)) if0 ();
  proc_flex_if #(.DW(16)) if1 ();
  proc_flex_if #(.DW(32)) if2 ();

  proc_flex #(.DW(16), .SIGNED_IMM(1'b0)) dut0 (.Clock(Clock), .Resetn(Resetn), .io(if0.slave));
  proc_flex #(.DW(16), .SIGNED_IMM(1'b1)) dut1 (.Clock(Clock), .Resetn(Resetn), .io(if1.slave));
  proc_flex #(.DW(32), .SIGNED_IMM(1'b0)) dut2 (.Clock(Clock), .Resetn(Resetn), .io(if2.slave));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [15:0] din_s [3];
  logic        run_s [3];
  logic [2:0]  sel_m [3];
  logic        done_w [3];
  logic [31:0] dbg_w [3];
  logic [2:0]  flg_w [3];

  assign if0.DIN = din_s[0];  assign if0.Run = run_s[0];  assign if0.DbgSel = sel_m[0];
  assign if1.DIN = din_s[1];  assign if1.Run = run_s[1];  assign if1.DbgSel = sel_m[1];
  assign if2.DIN = din_s[2];  assign if2.Run = run_s[2];  assign if2.DbgSel = sel_m[2];
  assign done_w[0] = if0.Done;  assign dbg_w[0] = {16'h0, if0.DbgData};  assign flg_w[0] = if0.Flags;
  assign done_w[1] = if1.Done;  assign dbg_w[1] = {16'h0, if1.DbgData};  assign flg_w[1] = if1.Flags;
  assign done_w[2] = if2.Done;  assign dbg_w[2] = if2.DbgData;           assign flg_w[2] = if2.Flags;

  typedef struct {
    int          d;
    int          cyc;
    int          rd;
    logic [31:0] val;
    logic [2:0]  fl;
  } exp_t;

  exp_t expq[$];
  exp_t probeq[$];
  bit   stim_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input int d, input logic [15:0] din, input logic run);
    din_s[d] = din;
    run_s[d] = run;
  endtask

  // Issue one instruction in a T0 cycle; Done is expected lat-1 cycles later.
  task automatic issue(input int d, input logic [15:0] din, input int lat, input int rd,
                       input logic [31:0] val, input logic [2:0] fl, input bit hold);
    exp_t e;
    @(negedge Clock);
    drive(d, din, 1'b1);
    e = '{d, cyc + lat - 1, rd, val, fl};
    expq.push_back(e);
    @(negedge Clock);
    if (!hold) run_s[d] = 1'b0;
    repeat (lat - 2) @(negedge Clock);
  endtask

  task automatic probe_all_zero();
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e = '{0, 0, r, 32'h0, 3'b000};
      probeq.push_back(e);
    end
    repeat (12) @(negedge Clock);
  endtask

  // Stimulus
  initial begin
    for (int d = 0; d < 3; d++) drive(d, 16'h0, 1'b0);
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    probe_all_zero();

    issue(0, 16'h1005, 2, 0, 32'h0005, 3'b000, 1'b0);  // mv  R0,#5
    issue(0, 16'h32A5, 2, 1, 32'hA500, 3'b000, 1'b0);  // mvt R1,#A5
    issue(0, 16'h4001, 4, 0, 32'hA505, 3'b100, 1'b0);  // add R0,R1
    issue(0, 16'hE000, 3, 0, 32'hA505, 3'b011, 1'b0);  // cmp R0,R0
    issue(0, 16'h1403, 2, 2, 32'h0003, 3'b011, 1'b0);  // mv  R2,#3
    issue(0, 16'h8001, 4, 0, 32'hA500, 3'b100, 1'b0);  // and R0,R1
    issue(0, 16'h7403, 4, 2, 32'h0000, 3'b011, 1'b0);  // sub R2,#3
    issue(0, 16'h7401, 4, 2, 32'hFFFF, 3'b100, 1'b0);  // sub R2,#1
    issue(0, 16'h5401, 4, 2, 32'h0000, 3'b011, 1'b0);  // add R2,#1
    issue(0, 16'hA401, 4, 2, 32'hA500, 3'b100, 1'b0);  // or  R2,R1
    issue(0, 16'hC201, 4, 1, 32'h0000, 3'b010, 1'b0);  // xor R1,R1
    issue(0, 16'hF005, 3, 0, 32'hA500, 3'b101, 1'b0);  // cmp R0,#5
    issue(0, 16'h17FF, 2, 3, 32'h01FF, 3'b101, 1'b0);  // mv  R3,#1FF
    issue(0, 16'h4000, 4, 0, 32'h4A00, 3'b001, 1'b0);  // add R0,R0

    issue(0, 16'h1807, 2, 4, 32'h0007, 3'b001, 1'b1);  // mv  R4,#7
    issue(0, 16'h4804, 4, 4, 32'h000E, 3'b000, 1'b1);  // add R4,R4
    issue(0, 16'h3A12, 2, 5, 32'h1200, 3'b000, 1'b0);  // mvt R5,#12
    repeat (3) @(negedge Clock);

    // add R0,R1 aborted by reset in its T2 step; no Done may follow.
    @(negedge Clock);
    drive(0, 16'h4001, 1'b1);
    @(negedge Clock);
    run_s[0] = 1'b0;
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    probe_all_zero();
    issue(0, 16'h1C09, 2, 6, 32'h0009, 3'b000, 1'b0);  // mv  R6,#9

    issue(1, 16'h17FF, 2, 3, 32'hFFFF, 3'b000, 1'b0);  // mv  R3,#-1 (sign-ext)
    issue(1, 16'h16FF, 2, 3, 32'h00FF, 3'b000, 1'b0);  // mv  R3,#FF
    issue(1, 16'h57FF, 4, 3, 32'h00FE, 3'b001, 1'b0);  // add R3,#-1

    issue(2, 16'h32A5, 2, 1, 32'h0000A500, 3'b000, 1'b0);  // mvt R1,#A5
    issue(2, 16'h7001, 4, 0, 32'hFFFFFFFF, 3'b100, 1'b0);  // sub R0,#1

    repeat (4) @(negedge Clock);
    stim_done = 1'b1;
  end

  // Monitor: sole owner of the counters and of DbgSel.
  initial begin
    logic        pend [3];
    logic [31:0] pv [3];
    logic [2:0]  pf [3];
    int          prd [3];
    exp_t        e;
    int          idx;
    for (int d = 0; d < 3; d++) begin
      pend[d] = 1'b0; pv[d] = '0; pf[d] = '0; prd[d] = 0; sel_m[d] = 3'd0;
    end
    forever begin
      @(negedge Clock);
      for (int d = 0; d < 3; d++) begin
        if (pend[d]) begin
          checks++;
          if (dbg_w[d] !== pv[d]) begin
            errors++;
            $display("FAIL dut%0d R%0d: got %h required %h", d, prd[d], dbg_w[d], pv[d]);
          end
          checks++;
          if (flg_w[d] !== pf[d]) begin
            errors++;
            $display("FAIL dut%0d flags after R%0d: got %b required %b", d, prd[d], flg_w[d], pf[d]);
          end
          pend[d] = 1'b0;
        end
        if (done_w[d] === 1'b1) begin
          idx = -1;
          foreach (expq[i]) if (idx < 0 && expq[i].d == d) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL dut%0d unexpected Done at cycle %0d: got 1 required 0", d, cyc);
          end else begin
            e = expq[idx];
            expq.delete(idx);
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL dut%0d Done cycle: got %0d required %0d", d, cyc, e.cyc);
            end
            sel_m[d] = 3'(e.rd);
            prd[d] = e.rd; pv[d] = e.val; pf[d] = e.fl; pend[d] = 1'b1;
          end
        end else if (d == 0 && probeq.size() > 0) begin
          e = probeq.pop_front();
          sel_m[0] = 3'(e.rd);
          prd[0] = e.rd; pv[0] = e.val; pf[0] = e.fl; pend[0] = 1'b1;
        end
      end
      if (cyc > 3000) begin
        errors++;
        $display("FAIL watchdog: cycle %0d reached, required stimulus end", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (stim_done) begin
        checks++;
        if (expq.size() != 0 || probeq.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expectations and %0d probes left, required 0",
                   expq.size(), probeq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
